// File: rtl/hit_trigger_scheduler_if.sv
// Purpose: hit-line / config / trigger-output bundle for hit_trigger_scheduler.
// Signals:
//   In_Hit_Sig    async active-low hit lines, one per chip (falling edge = hit)
//   Ch_Mask       per-channel enable
//   Cfg_Load      strobe loading Cfg_Width / Cfg_Dead
//   Cfg_Width     pulse width in cycles (0 behaves as 1)
//   Cfg_Dead      dead time in cycles after each pulse
//   Out_Hit_Sig   shared stretched hit output, active-low
//   Out_Hit_Ch    channel owning the current/last pulse
//   Out_Hit_Valid strobe in the first low cycle of each pulse
//   Pend          pending-request bits
//   Drop_Cnt      saturating count of hits lost to an already-pending request
// Modports: slave = scheduler side, master = hit source / consumer side.
interface hit_trigger_scheduler_if #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CW   = 8
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] In_Hit_Sig;
  logic [N_CH-1:0] Ch_Mask;
  logic            Cfg_Load;
  logic [CW-1:0]   Cfg_Width;
  logic [CW-1:0]   Cfg_Dead;
  logic            Out_Hit_Sig;
  logic [CH_W-1:0] Out_Hit_Ch;
  logic            Out_Hit_Valid;
  logic [N_CH-1:0] Pend;
  logic [15:0]     Drop_Cnt;

  modport slave (
    input  In_Hit_Sig, Ch_Mask, Cfg_Load, Cfg_Width, Cfg_Dead,
    output Out_Hit_Sig, Out_Hit_Ch, Out_Hit_Valid, Pend, Drop_Cnt
  );

  modport master (
    output In_Hit_Sig, Ch_Mask, Cfg_Load, Cfg_Width, Cfg_Dead,
    input  Out_Hit_Sig, Out_Hit_Ch, Out_Hit_Valid, Pend, Drop_Cnt
  );
endinterface

// File: rtl/hit_trigger_scheduler.sv
// Purpose: shares one stretched active-low hit-trigger output between N_CH
//   active-low chip hit lines. Falling edges are queued as pending requests,
//   granted round-robin, and each grant emits one low pulse of programmable
//   width followed by a programmable dead time.
// Ports:
//   Clk_In   80 MHz system clock
//   Rst      synchronous active-high reset
//   hit_bus  hit_trigger_scheduler_if.slave (hit lines, mask, config, outputs)
module hit_trigger_scheduler #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned CW        = 8,
  parameter int unsigned DEF_WIDTH = 20,
  parameter int unsigned DEF_DEAD  = 4
) (
  input  logic                   Clk_In,
  input  logic                   Rst,
  hit_trigger_scheduler_if.slave hit_bus
);

  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned NUM_W = $clog2(N_CH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    DEAD  = 2'd2
  } state_t;

  logic [N_CH-1:0]  sync_d1, sync_d2;
  logic [N_CH-1:0]  hit_evt;
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  grant_vec;
  logic [N_CH-1:0]  drop_vec;
  logic [NUM_W-1:0] drop_num;
  logic [16:0]      drop_sum;
  logic [15:0]      drop_q, drop_d;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    dead_lat_q, dead_lat_d;
  logic [CW-1:0]    w_act_q, d_act_q;
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic             out_sig_q, out_sig_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;

  logic             rr_found;
  logic [CH_W-1:0]  rr_idx;
  logic [CH_W-1:0]  cand;

  // Falling edge seen by the second sync stage, gated by the channel enable.
  assign hit_evt = ~sync_d1 & sync_d2 & hit_bus.Ch_Mask;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      cand = CH_W'((32'(ptr_q) + i) % N_CH);
      if (!rr_found && pend_q[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dead_lat_d  = dead_lat_q;
    out_sig_d   = out_sig_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    grant_vec   = '0;

    case (state_q)
      IDLE: begin
        out_sig_d = 1'b1;
        if (rr_found) begin
          grant_vec[rr_idx] = 1'b1;
          ptr_d             = rr_idx;
          out_ch_d          = rr_idx;
          out_sig_d         = 1'b0;
          out_valid_d       = 1'b1;
          // Counter holds remaining cycles minus one; width 0 behaves as 1.
          cnt_d             = (w_act_q == '0) ? '0 : w_act_q - CW'(1);
          dead_lat_d        = d_act_q;
          state_d           = PULSE;
        end
      end
      PULSE: begin
        out_sig_d = 1'b0;
        if (cnt_q == '0) begin
          out_sig_d = 1'b1;
          if (dead_lat_q != '0) begin
            cnt_d   = dead_lat_q - CW'(1);
            state_d = DEAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DEAD: begin
        out_sig_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        out_sig_d = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  // Pending bits and drop accounting; a hit coinciding with its own grant re-arms the request.
  always_comb begin
    pend_d   = ((pend_q & ~grant_vec) | hit_evt) & hit_bus.Ch_Mask;
    drop_vec = hit_evt & pend_q & ~grant_vec;
    drop_num = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      drop_num = drop_num + NUM_W'(drop_vec[i]);
    end
    drop_sum = {1'b0, drop_q} + 17'(drop_num);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // State and output registers.
  always_ff @(posedge Clk_In) begin
    if (Rst) begin
      sync_d1     <= '1;
      sync_d2     <= '1;
      pend_q      <= '0;
      drop_q      <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      dead_lat_q  <= '0;
      w_act_q     <= CW'(DEF_WIDTH);
      d_act_q     <= CW'(DEF_DEAD);
      ptr_q       <= CH_W'(N_CH - 1);
      out_sig_q   <= 1'b1;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sync_d1     <= hit_bus.In_Hit_Sig;
      sync_d2     <= sync_d1;
      pend_q      <= pend_d;
      drop_q      <= drop_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dead_lat_q  <= dead_lat_d;
      ptr_q       <= ptr_d;
      out_sig_q   <= out_sig_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      if (hit_bus.Cfg_Load) begin
        w_act_q <= hit_bus.Cfg_Width;
        d_act_q <= hit_bus.Cfg_Dead;
      end
    end
  end

  assign hit_bus.Out_Hit_Sig   = out_sig_q;
  assign hit_bus.Out_Hit_Ch    = out_ch_q;
  assign hit_bus.Out_Hit_Valid = out_valid_q;
  assign hit_bus.Pend          = pend_q;
  assign hit_bus.Drop_Cnt      = drop_q;

endmodule

// File: tb/tb_hit_trigger_scheduler.sv
// Bench for hit_trigger_scheduler: table of hit patterns plus hand-written
// sequences for drops, masking, mid-pulse reconfiguration and reset.
module tb_hit_trigger_scheduler;
  localparam int unsigned N_CH = 4;
  localparam int unsigned CW   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hit_trigger_scheduler_if #(.N_CH(N_CH), .CW(CW)) bus ();

  hit_trigger_scheduler #(
    .N_CH(N_CH), .CW(CW), .DEF_WIDTH(20), .DEF_DEAD(4)
  ) dut (
    .Clk_In (clk),
    .Rst    (rst),
    .hit_bus(bus.slave)
  );

  typedef struct {
    int ch;
    int width;
    int gap;     // high cycles before this pulse, -1 = not checked
  } exp_t;

  typedef struct {
    logic [3:0] hits;
    bit         load;
    int         w;
    int         d;
    int         n;
    int         e0, e1, e2, e3;
    int         width;
    int         gap;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[5];

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   prev_sig = 1'b1;
  int   low_len = 0;
  int   high_len = 0;
  int   cur_w = -1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input int width, input int gap);
    exp_t e;
    e.ch = ch; e.width = width; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic load_cfg(input int w, input int d);
    bus.Cfg_Width = 8'(w);
    bus.Cfg_Dead  = 8'(d);
    bus.Cfg_Load  = 1'b1;
    tick();
    bus.Cfg_Load  = 1'b0;
  endtask

  task automatic drain(input int budget);
    int cyc = 0;
    while ((sb.size() != 0 || bus.Out_Hit_Sig == 1'b0) && cyc < budget) begin
      tick();
      cyc++;
    end
    if (cyc >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d pulses outstanding after %0d cycles, required 0", sb.size(), budget);
      sb.delete();
    end
    repeat (2) tick();
  endtask

  task automatic wait_valid(input int budget);
    int cyc = 0;
    while (bus.Out_Hit_Valid !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
    if (cyc >= budget) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: no Out_Hit_Valid within %0d cycles, required 1", budget);
    end
  endtask

  function automatic int pick(input vec_t v, input int j);
    case (j)
      0:       return v.e0;
      1:       return v.e1;
      2:       return v.e2;
      default: return v.e3;
    endcase
  endfunction

  // Pulse monitor: measures each low pulse and its preceding high gap, checks against the scoreboard.
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_sig = 1'b1;
      low_len  = 0;
      high_len = 0;
      cur_w    = -1;
    end else if (!bus.Out_Hit_Sig && prev_sig) begin
      check("valid_first", int'(bus.Out_Hit_Valid), 1);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got pulse on ch %0d, required none", int'(bus.Out_Hit_Ch));
        cur_w = -1;
      end else begin
        mon_e = sb.pop_front();
        check("pulse_ch", int'(bus.Out_Hit_Ch), mon_e.ch);
        if (mon_e.gap >= 0) check("pulse_gap", high_len, mon_e.gap);
        cur_w = mon_e.width;
      end
      low_len  = 1;
      prev_sig = 1'b0;
    end else if (!bus.Out_Hit_Sig) begin
      check("valid_low", int'(bus.Out_Hit_Valid), 0);
      low_len++;
    end else if (!prev_sig) begin
      if (cur_w >= 0) check("pulse_width", low_len, cur_w);
      check("valid_end", int'(bus.Out_Hit_Valid), 0);
      high_len = 1;
      prev_sig = 1'b1;
    end else begin
      high_len++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // hits, load, w, d, n, order e0..e3, width, gap between pulses
    vecs[0] = '{4'b0001, 1'b0, 0, 0, 1, 0, 0, 0, 0, 20, 5};
    vecs[1] = '{4'b1010, 1'b0, 0, 0, 2, 1, 3, 0, 0, 20, 5};
    vecs[2] = '{4'b0101, 1'b1, 3, 2, 2, 0, 2, 0, 0,  3, 3};
    vecs[3] = '{4'b1111, 1'b1, 0, 0, 4, 3, 0, 1, 2,  1, 1};
    vecs[4] = '{4'b0110, 1'b1, 5, 0, 2, 1, 2, 0, 0,  5, 1};

    rst            = 1'b1;
    bus.In_Hit_Sig = '1;
    bus.Ch_Mask    = '1;
    bus.Cfg_Load   = 1'b0;
    bus.Cfg_Width  = '0;
    bus.Cfg_Dead   = '0;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_sig",   int'(bus.Out_Hit_Sig),   1);
    check("rst_ch",    int'(bus.Out_Hit_Ch),    0);
    check("rst_valid", int'(bus.Out_Hit_Valid), 0);
    check("rst_pend",  int'(bus.Pend),          0);
    check("rst_drop",  int'(bus.Drop_Cnt),      0);
    mon_en = 1'b1;
    tick();

    // Table-driven hit patterns.
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].load) load_cfg(vecs[i].w, vecs[i].d);
      for (int j = 0; j < vecs[i].n; j++)
        push(pick(vecs[i], j), vecs[i].width, (j == 0) ? -1 : vecs[i].gap);
      bus.In_Hit_Sig = ~vecs[i].hits;
      drain(500);
      bus.In_Hit_Sig = '1;
      repeat (3) tick();
    end
    check("table_drop", int'(bus.Drop_Cnt), 0);

    // Repeated ch2 hits during a ch0 pulse: one request, two drops.
    load_cfg(20, 4);
    push(0, 20, -1);
    push(2, 20, 5);
    bus.In_Hit_Sig[0] = 1'b0;
    wait_valid(20);
    for (int k = 0; k < 3; k++) begin
      bus.In_Hit_Sig[2] = 1'b0;
      repeat (3) tick();
      check("pend2_set", int'(bus.Pend[2]), 1);
      bus.In_Hit_Sig[2] = 1'b1;
      repeat (3) tick();
    end
    drain(500);
    check("drop_cnt", int'(bus.Drop_Cnt), 2);
    bus.In_Hit_Sig = '1;
    repeat (3) tick();

    // Masking clears a pending request and suppresses masked hits.
    push(0, 20, -1);
    bus.In_Hit_Sig[0] = 1'b0;
    wait_valid(20);
    bus.In_Hit_Sig[1] = 1'b0;
    repeat (3) tick();
    check("pend1_set", int'(bus.Pend[1]), 1);
    bus.Ch_Mask = 4'b1101;
    tick();
    check("pend1_masked", int'(bus.Pend[1]), 0);
    bus.In_Hit_Sig[1] = 1'b1;
    repeat (3) tick();
    bus.In_Hit_Sig[1] = 1'b0;
    repeat (3) tick();
    check("pend1_masked_hit", int'(bus.Pend[1]), 0);
    bus.In_Hit_Sig[1] = 1'b1;
    repeat (3) tick();
    bus.Ch_Mask = '1;
    drain(500);
    check("drop_masked", int'(bus.Drop_Cnt), 2);
    bus.In_Hit_Sig = '1;
    repeat (3) tick();

    // Reconfiguring mid-pulse keeps the latched width; next grant uses the new one.
    load_cfg(10, 0);
    push(3, 10, -1);
    bus.In_Hit_Sig[3] = 1'b0;
    wait_valid(20);
    repeat (3) tick();
    load_cfg(50, 0);
    drain(500);
    bus.In_Hit_Sig = '1;
    repeat (3) tick();
    push(0, 50, -1);
    bus.In_Hit_Sig[0] = 1'b0;
    drain(500);
    bus.In_Hit_Sig = '1;
    repeat (3) tick();

    // Reset in cycle 10 of a pulse with another request pending.
    mon_en = 1'b0;
    bus.In_Hit_Sig = 4'b1001;
    wait_valid(20);
    repeat (9) tick();
    check("pre_rst_sig", int'(bus.Out_Hit_Sig), 0);
    rst            = 1'b1;
    bus.In_Hit_Sig = '1;
    tick();
    rst = 1'b0;
    check("mid_rst_sig",   int'(bus.Out_Hit_Sig),   1);
    check("mid_rst_pend",  int'(bus.Pend),          0);
    check("mid_rst_drop",  int'(bus.Drop_Cnt),      0);
    check("mid_rst_ch",    int'(bus.Out_Hit_Ch),    0);
    check("mid_rst_valid", int'(bus.Out_Hit_Valid), 0);
    repeat (3) tick();
    mon_en = 1'b1;
    push(0, 20, -1);
    bus.In_Hit_Sig[0] = 1'b0;
    drain(500);
    bus.In_Hit_Sig = '1;
    repeat (10) tick();
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
